// File: rtl/sq_wave_pkg.sv
// rtl/sq_wave_pkg.sv - shared types and constants for the square wave meter
package sq_wave_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meter_state_t;

    localparam int CLK_PERIOD_NS  = 10;
    // Matches the generator's 10*m / 10*n scaling so ticks read directly as m/n.
    localparam int TICK_DIV_100NS = 10;

endpackage

// File: rtl/square_wave_meter_if.sv
// rtl/square_wave_meter_if.sv - measured waveform in, phase measurements out
interface square_wave_meter_if #(
    parameter int W = 8
);
    logic         sig_in;
    logic [W-1:0] high_ticks;
    logic [W-1:0] low_ticks;
    logic [W:0]   period_ticks;
    logic         meas_valid;
    logic         stuck_high;
    logic         stuck_low;

    modport master (
        output sig_in,
        input  high_ticks, low_ticks, period_ticks, meas_valid, stuck_high, stuck_low
    );

    modport slave (
        input  sig_in,
        output high_ticks, low_ticks, period_ticks, meas_valid, stuck_high, stuck_low
    );
endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer plus delay flop with rise/fall detect
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign q    = r_s2;
    assign rise = r_s2 & ~r_s3;
    assign fall = ~r_s2 & r_s3;
endmodule

// File: rtl/square_wave_meter.sv
// rtl/square_wave_meter.sv - measures high/low phase lengths in ticks and flags stalls
module square_wave_meter
    import sq_wave_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_100NS,
    parameter int W        = 8,
    parameter int TIMEOUT  = 200
) (
    input  logic                clk,
    input  logic                rst,
    square_wave_meter_if.slave  bus
);
    localparam int           PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST   = PW'(TICK_DIV - 1);
    localparam logic [W-1:0]  TICK_MAX = '1;
    localparam logic [W-1:0]  TMO      = W'(TIMEOUT);

    logic         w_level;
    logic         w_rise;
    logic         w_fall;
    logic         w_edge;
    logic         w_timeout;

    meter_state_t r_state;
    meter_state_t w_next;
    logic         w_latch_hold;
    logic         w_emit;
    logic         w_set_hi;
    logic         w_set_lo;

    logic [PW-1:0] r_p;
    logic [W-1:0]  r_ticks;
    logic [W-1:0]  r_hold_high;
    logic          r_hi_ok;
    logic [W-1:0]  r_high_ticks;
    logic [W-1:0]  r_low_ticks;
    logic [W:0]    r_period_ticks;
    logic          r_meas_valid;
    logic          r_stuck_high;
    logic          r_stuck_low;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.sig_in),
        .q    (w_level),
        .rise (w_rise),
        .fall (w_fall)
    );

    assign w_edge    = w_rise | w_fall;
    // An edge always wins over a timeout landing on the same cycle.
    assign w_timeout = ~w_edge && (r_ticks == TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_latch_hold = 1'b0;
        w_emit       = 1'b0;
        w_set_hi     = 1'b0;
        w_set_lo     = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_rise) begin
                    w_next = HIGH;
                end else if (w_fall) begin
                    w_next = LOW;
                end else if (w_timeout) begin
                    w_set_hi = w_level;
                    w_set_lo = ~w_level;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_latch_hold = 1'b1;
                    w_next       = LOW;
                end else if (w_timeout) begin
                    w_set_hi = 1'b1;
                    w_next   = SYNC;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_emit = r_hi_ok;
                    w_next = HIGH;
                end else if (w_timeout) begin
                    w_set_lo = 1'b1;
                    w_next   = SYNC;
                end
            end
            default: w_next = SYNC;
        endcase
    end

    // The edge cycle is clock 1 of the new phase, hence p restarts at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_ticks <= '0;
        end else if (w_edge) begin
            r_p     <= PW'(1);
            r_ticks <= '0;
        end else if (r_p == P_LAST) begin
            r_p     <= '0;
            r_ticks <= (r_ticks == TICK_MAX) ? r_ticks : r_ticks + 1'b1;
        end else begin
            r_p <= r_p + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_high    <= '0;
            r_hi_ok        <= 1'b0;
            r_high_ticks   <= '0;
            r_low_ticks    <= '0;
            r_period_ticks <= '0;
            r_meas_valid   <= 1'b0;
            r_stuck_high   <= 1'b0;
            r_stuck_low    <= 1'b0;
        end else begin
            r_meas_valid <= w_emit;
            if (w_latch_hold) begin
                r_hold_high <= r_ticks;
                r_hi_ok     <= 1'b1;
            end else if (w_set_hi | w_set_lo) begin
                r_hi_ok <= 1'b0;
            end
            if (w_emit) begin
                r_high_ticks   <= r_hold_high;
                r_low_ticks    <= r_ticks;
                r_period_ticks <= {1'b0, r_hold_high} + {1'b0, r_ticks};
            end
            if (w_edge) begin
                r_stuck_high <= 1'b0;
                r_stuck_low  <= 1'b0;
            end else begin
                if (w_set_hi) r_stuck_high <= 1'b1;
                if (w_set_lo) r_stuck_low  <= 1'b1;
            end
        end
    end

    assign bus.high_ticks   = r_high_ticks;
    assign bus.low_ticks    = r_low_ticks;
    assign bus.period_ticks = r_period_ticks;
    assign bus.meas_valid   = r_meas_valid;
    assign bus.stuck_high   = r_stuck_high;
    assign bus.stuck_low    = r_stuck_low;
endmodule
